draw_grid: RTL
==============

DRAW_GRID -- requirements
Module: draw_grid

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- X0, 0, left pixel column of play area
- Y0, 30, top pixel row of play area
- CELL_W, 32, cell width in pixels (>=4)
- CELL_H, 32, cell height in pixels (>=4)
- COLS, 24, cell columns (1..32)
- ROWS, 17, cell rows (1..32)
- BORDER, 2, outer border thickness in pixels (1..CELL_W/2)
- BLINK_FRAMES, 30, frames per cursor blink half-period
- LINE_RGB, 12'hFFF, border/grid-line colour
- BG_RGB, 12'h000, background colour
- CUR_RGB, 12'hF00, cursor fill colour
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, pixel clock
- rst, in, 1, asynchronous active-high reset
- hcount, in, 11, current pixel column from VGA timing generator
- vcount, in, 10, current pixel row from VGA timing generator
- cursor_col, in, 5, requested cursor column
- cursor_row, in, 5, requested cursor row
- cursor_load, in, 1, one-cycle strobe capturing cursor_col/cursor_row
- cursor_en, in, 1, 1 = draw cursor
- blink_en, in, 1, 1 = cursor blinks; 0 = cursor steady
- pixel, out, 12, RGB444 pixel
- in_grid, out, 1, pixel lies inside play area
- cell_col, out, 5, cell column of pixel (0 outside area)
- cell_row, out, 5, cell row of pixel (0 outside area)

Function
REQ-003 Fixed 2-cycle latency: pixel, in_grid, cell_col, cell_row at edge t+2 describe (hcount, vcount) sampled at edge t; all outputs registered.
REQ-004 Play area: X0 <= hcount < X0+COLS*CELL_W and Y0 <= vcount < Y0+ROWS*CELL_H.
REQ-005 Cell indices derived by incrementing sub-pixel/cell counters (no divider): horizontal counters restart at hcount==X0, vertical counters restart when hcount==0 and vcount==Y0, advance one row-pixel per hcount==0.
REQ-006 Inputs contract: hcount increments by 1 per clk within a line; vcount changes only when hcount==0.
REQ-007 Colour priority: outside area -> BG_RGB; within BORDER pixels of any area edge -> LINE_RGB; first pixel column/row of any cell -> LINE_RGB; cursor cell interior with cursor visible -> CUR_RGB; else BG_RGB.
REQ-008 Cursor visible = cursor_en AND (blink_en==0 OR blink_phase==1).
REQ-009 Frame start = hcount==0 AND vcount==0; frame counter increments there, wraps at BLINK_FRAMES-1 and toggles blink_phase on wrap.
REQ-010 cursor_load captures inputs into pending register; values with cursor_col>=COLS or cursor_row>=ROWS are discarded, pending unchanged.
REQ-011 Pending cursor commits to active cursor only at frame start (tear-free); load coinciding with frame start commits at the following frame start; last load before frame start wins.

Reset
REQ-012 rst asserted: pixel=BG_RGB... 12'h000, in_grid=0, cell_col=0, cell_row=0, counters=0, blink_phase=1, active and pending cursor=(0,0), pending-valid=0; effective immediately, asynchronously.
REQ-013 After rst release mid-frame, outputs are correct from the next frame start onward; earlier pixels are don't-care for checking.

Structure
REQ-014 Package draw_pkg holds RGB444 colour constants, visible 1024x768 limits, and cell-index width constant.
REQ-015 Blink counter is a sub-module frame_blink (inputs clk, rst, frame_start; output blink_phase).

Verification
REQ-016 Defaults, full frame, cursor_en=0: pixel(0,30)=12'hFFF, (1,31)=12'hFFF, (2,32)=12'h000, (32,40)=12'hFFF, (100,20)=12'h000.
REQ-017 hcount=70,vcount=100 -> two cycles later cell_col=2, cell_row=2, in_grid=1; hcount=800 -> in_grid=0, cell_col=0.
REQ-018 cursor_load (3,4), cursor_en=1, blink_en=0 -> unchanged until next frame start, then pixel(110,170)=12'hF00, grid lines at (96,170) stay 12'hFFF.
REQ-019 blink_en=1, BLINK_FRAMES=2 -> cursor fill visible frames 0-1, hidden 2-3, visible 4-5.
REQ-020 cursor_load (24,0) -> ignored, cursor stays at previous cell; load at frame-start cycle -> commits one frame later.
REQ-021 rst asserted mid-line -> pixel=12'h000 same cycle; blink_phase=1, cursor at (0,0) after release.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared constants and types for the grid renderer.
//   RGB444 colour constants, visible-raster limits of the 1024x768 VGA mode,
//   cell-index width and the cell coordinate type used for the cursor.
package draw_pkg;

  localparam int IDX_W = 5;
  localparam int H_VIS = 1024;
  localparam int V_VIS = 768;

  typedef logic [11:0]      rgb_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    idx_t col;
    idx_t row;
  } cell_t;

  localparam rgb_t RGB_BLACK = 12'h000;
  localparam rgb_t RGB_WHITE = 12'hFFF;
  localparam rgb_t RGB_RED   = 12'hF00;

endpackage

// File: rtl/draw_grid_frame_blink.sv
// Cursor blink timer.
//   clk, rst     : pixel clock, asynchronous active-high reset
//   frame_start  : one-cycle pulse at raster position (0,0)
//   blink_phase  : 1 = cursor shown in the current frame
// The phase changes only at frame starts, so a frame is never torn. The
// phase presented for a frame is the one computed at the previous frame
// start, which makes the first phase after reset last BLINK_FRAMES frames.
module frame_blink #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  output logic blink_phase
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] frame_cnt;
  logic             phase_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt   <= '0;
      phase_nxt   <= 1'b1;
      blink_phase <= 1'b1;
    end else if (frame_start) begin
      blink_phase <= phase_nxt;
      if (frame_cnt == LAST) begin
        frame_cnt <= '0;
        phase_nxt <= ~phase_nxt;
      end else begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/draw_grid.sv
// Grid / cursor renderer for a cell-based play area on a VGA raster.
//   clk, rst                 : pixel clock, asynchronous active-high reset
//   hcount, vcount           : raster position from the timing generator
//   cursor_col/row, _load    : cursor request, captured on the load strobe
//   cursor_en, blink_en      : cursor drawing / blinking enables
//   pixel                    : RGB444 colour, two cycles after hcount/vcount
//   in_grid, cell_col/row    : play-area membership and cell of that pixel
// Cell indices come from counters that follow the raster, so no divider is
// needed; they rely on hcount stepping by one per clock within a line.
module draw_grid
  import draw_pkg::*;
#(
  parameter int   X0           = 0,
  parameter int   Y0           = 30,
  parameter int   CELL_W       = 32,
  parameter int   CELL_H       = 32,
  parameter int   COLS         = 24,
  parameter int   ROWS         = 17,
  parameter int   BORDER       = 2,
  parameter int   BLINK_FRAMES = 30,
  parameter rgb_t LINE_RGB     = RGB_WHITE,
  parameter rgb_t BG_RGB       = RGB_BLACK,
  parameter rgb_t CUR_RGB      = RGB_RED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [4:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  input  logic        cursor_load,
  input  logic        cursor_en,
  input  logic        blink_en,
  output logic [11:0] pixel,
  output logic        in_grid,
  output logic [4:0]  cell_col,
  output logic [4:0]  cell_row
);

  localparam logic [10:0] X_LO      = 11'(X0);
  localparam logic [10:0] X_SPAN    = 11'(COLS * CELL_W);
  localparam logic [10:0] XB_HI     = 11'(COLS * CELL_W - BORDER);
  localparam logic [9:0]  Y_LO      = 10'(Y0);
  localparam logic [9:0]  Y_SPAN    = 10'(ROWS * CELL_H);
  localparam logic [9:0]  YB_HI     = 10'(ROWS * CELL_H - BORDER);
  localparam logic [10:0] XB_LO     = 11'(BORDER);
  localparam logic [9:0]  YB_LO     = 10'(BORDER);
  localparam logic [10:0] HSUB_LAST = 11'(CELL_W - 1);
  localparam logic [9:0]  VSUB_LAST = 10'(CELL_H - 1);
  localparam logic [5:0]  COLS_W    = 6'(COLS);
  localparam logic [5:0]  ROWS_W    = 6'(ROWS);

  function automatic rgb_t pick_rgb(input logic in_area, input logic bord,
                                    input logic line_px, input logic cur_px);
    rgb_t rgb;
    if (!in_area)              rgb = BG_RGB;
    else if (bord || line_px)  rgb = LINE_RGB;
    else if (cur_px)           rgb = CUR_RGB;
    else                       rgb = BG_RGB;
    return rgb;
  endfunction

  logic        frame_start;
  logic        blink_phase;
  logic        load_ok;
  cell_t       act_q, pend_q;
  logic        pend_vld_q;

  logic [10:0] hsub_q, hsub_c;
  idx_t        hcol_q, hcol_c;
  logic [9:0]  vsub_q, vsub_c;
  idx_t        vrow_q, vrow_c;

  logic [10:0] dx;
  logic [9:0]  dy;
  logic        in_area_c, border_c, line_c, cur_c;

  logic        in_area_p0, border_p0, line_p0, cur_p0;
  idx_t        col_p0, row_p0;

  assign frame_start = (hcount == '0) && (vcount == '0);
  assign load_ok     = cursor_load && ({1'b0, cursor_col} < COLS_W)
                                   && ({1'b0, cursor_row} < ROWS_W);

  frame_blink #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .blink_phase (blink_phase)
  );

  // Pending cursor is double-buffered and only promoted at frame start; a
  // load in the same cycle lands in pending after the promotion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      if (frame_start && pend_vld_q) begin
        act_q      <= pend_q;
        pend_vld_q <= 1'b0;
      end
      if (load_ok) begin
        pend_q     <= '{col: cursor_col, row: cursor_row};
        pend_vld_q <= 1'b1;
      end
    end
  end

  // Counter values for the pixel currently on hcount/vcount. The registers
  // hold the prediction for the next pixel; restarts override them.
  always_comb begin
    hsub_c = hsub_q;
    hcol_c = hcol_q;
    vsub_c = vsub_q;
    vrow_c = vrow_q;
    if (hcount == X_LO) begin
      hsub_c = '0;
      hcol_c = '0;
    end
    if (hcount == '0) begin
      if (vcount == Y_LO) begin
        vsub_c = '0;
        vrow_c = '0;
      end else if (vsub_q == VSUB_LAST) begin
        vsub_c = '0;
        vrow_c = vrow_q + IDX_W'(1);
      end else begin
        vsub_c = vsub_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsub_q <= '0;
      hcol_q <= '0;
      vsub_q <= '0;
      vrow_q <= '0;
    end else begin
      hsub_q <= (hsub_c == HSUB_LAST) ? '0 : hsub_c + 11'd1;
      hcol_q <= (hsub_c == HSUB_LAST) ? hcol_c + IDX_W'(1) : hcol_c;
      vsub_q <= vsub_c;
      vrow_q <= vrow_c;
    end
  end

  // Offsets wrap to large values left of / above the area, so a single
  // unsigned compare covers both sides.
  always_comb begin
    dx        = hcount - X_LO;
    dy        = vcount - Y_LO;
    in_area_c = (dx < X_SPAN) && (dy < Y_SPAN) &&
                (hcount < 11'(H_VIS)) && (vcount < 10'(V_VIS));
    border_c  = (dx < XB_LO) || (dx >= XB_HI) || (dy < YB_LO) || (dy >= YB_HI);
    line_c    = (hsub_c == '0) || (vsub_c == '0);
    cur_c     = cursor_en && (!blink_en || blink_phase) &&
                (hcol_c == act_q.col) && (vrow_c == act_q.row);
  end

  // ---- stage p0: classify pixel ----
  always_ff @(posedge clk) begin
    in_area_p0 <= in_area_c;
    border_p0  <= border_c;
    line_p0    <= line_c;
    cur_p0     <= cur_c;
    col_p0     <= hcol_c;
    row_p0     <= vrow_c;
  end

  // ---- stage p1: registered outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel    <= BG_RGB;
      in_grid  <= 1'b0;
      cell_col <= '0;
      cell_row <= '0;
    end else begin
      pixel    <= pick_rgb(in_area_p0, border_p0, line_p0, cur_p0);
      in_grid  <= in_area_p0;
      cell_col <= in_area_p0 ? col_p0 : '0;
      cell_row <= in_area_p0 ? row_p0 : '0;
    end
  end

endmodule
